bram_lsu: RTL

- Load/store initiator that drives one port of the dual-port word BRAM on behalf of the CPU.
- Converts byte-addressed byte/halfword/word requests into 32-bit word accesses, little-endian.
- The BRAM has no byte enables, so sub-word stores are done as read-modify-write.
- Loads are returned zero- or sign-extended. Sits between the core's memory stage and BRAM port A or B.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/bram_lsu_align.sv | 42 ++++
 rtl/bram_lsu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the BRAM load/store unit.
package lsu_pkg;

  localparam int WORD_WIDTH = 32;

  // Access size encoding as it arrives on the request bus; 2'b11 is illegal.
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_t;

  // Sequencer states; every state other than IDLE lasts exactly one cycle.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/bram_lsu_align.sv
// Byte-lane steering for the load/store unit: little-endian store merge
// (read-modify-write data path) and load extract with zero/sign extension.
import lsu_pkg::*;

module bram_lsu_align (
  input  logic [WORD_WIDTH-1:0] mem_word,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [1:0]            lane,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [WORD_WIDTH-1:0] merged_word,
  output logic [WORD_WIDTH-1:0] load_data
);

  logic [WORD_WIDTH-1:0] shifted;
  logic                  fill_b;
  logic                  fill_h;

  // Overlay the right-aligned store data onto the addressed lane(s) of the old word.
  always_comb begin
    merged_word = mem_word;
    case (size)
      SIZE_B:  merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
      SIZE_H:  merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged_word = wdata;
    endcase
  end

  // Right-align the addressed lane(s) and extend to a full word.
  always_comb begin
    shifted   = mem_word >> {lane, 3'b000};
    fill_b    = !is_unsigned && shifted[7];
    fill_h    = !is_unsigned && shifted[15];
    load_data = shifted;
    case (size)
      SIZE_B:  load_data = {{24{fill_b}}, shifted[7:0]};
      SIZE_H:  load_data = {{16{fill_h}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/bram_lsu.sv
// Load/store initiator for one port of a word-wide BRAM without byte enables.
// Sub-word stores are read-modify-write; the other BRAM port is not locked out
// between the read and the write, so software must arbitrate shared words.
import lsu_pkg::*;

module bram_lsu #(
  parameter int BRAM_ADDR_WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_write,
  input  logic [1:0]                 i_req_size,
  input  logic                       i_req_unsigned,
  input  logic [31:0]                i_req_addr,
  input  logic [WORD_WIDTH-1:0]      i_req_wdata,
  output logic                       o_resp_valid,
  output logic [WORD_WIDTH-1:0]      o_resp_rdata,
  output logic                       o_resp_err,
  output logic [BRAM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WORD_WIDTH-1:0]      o_mem_wdata,
  output logic                       o_mem_write,
  input  logic [WORD_WIDTH-1:0]      i_mem_rdata
);

  state_t state;
  state_t state_next;

  logic                       req_write;
  logic [1:0]                 req_size;
  logic                       req_unsigned;
  logic [BRAM_ADDR_WIDTH-1:0] req_index;
  logic [1:0]                 req_lane;
  logic [WORD_WIDTH-1:0]      req_wdata;
  logic                       req_err;
  logic [WORD_WIDTH-1:0]      result;

  logic                       accept;
  logic                       addr_err;
  logic [31:0]                high_bits;
  logic                       is_word_store;
  logic [WORD_WIDTH-1:0]      merged_word;
  logic [WORD_WIDTH-1:0]      load_data;

  assign accept    = i_req_valid && o_req_ready;
  assign high_bits = i_req_addr >> (BRAM_ADDR_WIDTH + 2);

  // Classify the incoming request as illegal: bad size, misalignment or beyond the BRAM.
  always_comb begin
    addr_err = 1'b0;
    if (i_req_size == 2'b11)                                  addr_err = 1'b1;
    if ((i_req_size == SIZE_H) && i_req_addr[0])              addr_err = 1'b1;
    if ((i_req_size == SIZE_W) && (i_req_addr[1:0] != 2'b00)) addr_err = 1'b1;
    if (high_bits != 32'd0)                                   addr_err = 1'b1;
  end

  assign is_word_store = req_write && (req_size == SIZE_W);

  bram_lsu_align u_align (
    .mem_word    (i_mem_rdata),
    .wdata       (req_wdata),
    .lane        (req_lane),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Latch every request field on accept so the bus can move on immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_write    <= 1'b0;
      req_size     <= 2'b00;
      req_unsigned <= 1'b0;
      req_index    <= '0;
      req_lane     <= 2'b00;
      req_wdata    <= '0;
      req_err      <= 1'b0;
    end else if (accept) begin
      req_write    <= i_req_write;
      req_size     <= i_req_size;
      req_unsigned <= i_req_unsigned;
      req_index    <= i_req_addr[BRAM_ADDR_WIDTH+1:2];
      req_lane     <= i_req_addr[1:0];
      req_wdata    <= i_req_wdata;
      req_err      <= addr_err;
    end
  end

  // Capture either the merged store word or the extended load data from BRAM.
  always_ff @(posedge i_clk) begin
    if (i_rst)                  result <= '0;
    else if (state == CAPTURE)  result <= req_write ? merged_word : load_data;
  end

  // Sequencing and BRAM/response outputs; writes are squashed while reset is high.
  always_comb begin
    state_next   = state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_err   = 1'b0;
    o_resp_rdata = '0;
    o_mem_addr   = req_index;
    o_mem_wdata  = req_wdata;
    o_mem_write  = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_next = addr_err ? RESP : ISSUE;
      end
      ISSUE: begin
        o_mem_write = is_word_store && !i_rst;
        state_next  = is_word_store ? RESP : CAPTURE;
      end
      CAPTURE: begin
        state_next = req_write ? WRITE : RESP;
      end
      WRITE: begin
        o_mem_wdata = result;
        o_mem_write = !i_rst;
        state_next  = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        o_resp_err   = req_err;
        if (!req_err && !req_write) o_resp_rdata = result;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
